mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Shares the single 64-bit doubleword read port of `mem` between the instruction-fetch requester and the data-load (`ld`/`ldu`) requester of the multi-cycle PowerPC core. It sequences each access through a fixed-latency address/data cycle, returns read data to the winning requester, and keeps fetch from being starved by a stream of loads. It sits between the core's fetch/load stages and one `readAddr`/`readData` pair of `mem`.

## Interface

- `LAT`, default 1: cycles from address issue to data sample; legal 1..7.
- `STARVE_LIMIT`, default 3: consecutive load grants allowed while fetch waits; legal 1..15.

- `clk`  in  1  system clock, from `clock`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held with `f_addr` stable until `f_ack`.
- `f_addr`  in  [0:60]  fetch doubleword address.
- `f_ack`  out  1  fetch request accepted this cycle.
- `f_valid`  out  1  one-cycle pulse; `rdata` holds fetch data.
- `d_req`  in  1  load request; held with `d_addr` stable until `d_ack`.
- `d_addr`  in  [0:60]  load doubleword address.
- `d_ack`  out  1  load request accepted this cycle.
- `d_valid`  out  1  one-cycle pulse; `rdata` holds load data.
- `rdata`  out  [0:63]  registered read data, shared by both requesters.
- `mem_addr`  out  [0:60]  registered address to `mem` read port.
- `mem_data`  in  [0:63]  data from `mem` read port.
- `busy`  out  1  high when state is not IDLE.

## Operation

- States: IDLE, WAIT.
- IDLE: combinational arbitration on `f_req`/`d_req`. Only one requester asserting: that requester wins. Both asserting: load wins unless `starve == STARVE_LIMIT`, in which case fetch wins.
- Winner's `ack` is asserted combinationally in the same IDLE cycle. No `ack` is ever asserted in WAIT.
- Acceptance edge: `mem_addr <= winner addr`, `owner <= winner`, `cnt <= LAT`, state becomes WAIT.
- WAIT: `cnt` decrements each edge. On the edge where `cnt == 1`:
  - `rdata <= mem_data`.
  - The owner's `valid` is set for one cycle.
  - State returns to IDLE.
- `mem_addr` holds its last value outside WAIT. `rdata` holds its value until the next capture.
- Starve counter, 4 bits:
  - +1 on each load grant made while `f_req` is high.
  - Cleared on any fetch grant.
  - Cleared in any IDLE cycle with `f_req` low.
  - Saturates at `STARVE_LIMIT`.
- Dropping `req` before `ack` withdraws the request with no side effect. Dropping `req` after `ack` does not cancel the transaction; `valid` still pulses.
- Reset (asynchronous, any state):
  - State IDLE; `cnt`, `starve`, `owner` = 0.
  - `mem_addr` = 0, `rdata` = 0.
  - `f_valid` = `d_valid` = 0, `busy` = 0.
  - An in-flight transaction is dropped and no `valid` follows.

## Timing

- Accept in cycle T. `mem_addr` is valid in T+1..T+LAT. `valid` and `rdata` are presented in T+LAT+1.
- State is IDLE in T+LAT+1, so a new accept may coincide with the previous `valid` pulse.
- Peak throughput: one access per LAT+1 cycles.
- `f_ack`/`d_ack` are combinational from `req` and state. `valid`, `rdata`, `mem_addr` and `busy` are registered.
- `f_valid` and `d_valid` are never high together. At most one `ack` per cycle.

## Test plan

- Reset: assert `rst_n` = 0 in the second WAIT cycle (LAT=3), release 2 cycles later. Required: all outputs 0 during reset and no `valid` ever issued for the dropped access.
- Single fetch, LAT=1: `f_req` with `f_addr` = 0x10 in cycle 0. Required: `f_ack` in cycle 0, `mem_addr` = 0x10 in cycle 1, `f_valid` = 1 with `rdata` = mem[0x10] in cycle 2, `busy` = 1 only in cycle 1.
- Contention, LAT=1, STARVE_LIMIT=3: `f_req` and `d_req` held continuously. Required grant order D,D,D,F,D,D,D,F, with a grant every 2 cycles.
- LAT=3, back-to-back loads to 0x20, 0x21, 0x22. Required: `d_ack` in cycles 0, 4, 8; `d_valid` in cycles 4, 8, 12 with the matching data; each ack coincides with the previous `valid`.
- Late request: `d_req` raised in cycle 1 of a fetch WAIT (LAT=2). Required: no `d_ack` until the IDLE cycle carrying `f_valid` (cycle 3), then `d_valid` in cycle 6.
- Withdrawal: `d_req` pulsed high for one cycle while `busy`. Required: no `d_ack`, no `d_valid`, and starve unchanged; `f_req` low resets starve to 0.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: fetch/load request channels plus the shared mem read port.
interface mem_read_arbiter_if;
  logic f_req, f_ack, f_valid, d_req, d_ack, d_valid, busy;
  logic [0:60] f_addr, d_addr, mem_addr;
  logic [0:63] rdata, mem_data;
  modport master(
    output f_req, f_addr, d_req, d_addr, mem_data,
    input  f_ack, f_valid, d_ack, d_valid, rdata, mem_addr, busy
  );
  modport slave(
    input  f_req, f_addr, d_req, d_addr, mem_data,
    output f_ack, f_valid, d_ack, d_valid, rdata, mem_addr, busy
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one fixed-latency mem read port between fetch and load,
// favouring loads but forcing a fetch grant after STARVE_LIMIT consecutive load wins.
module mem_read_arbiter #(
  parameter int LAT = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst_n,
  mem_read_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, stateNext;
  logic [2:0] cnt;
  logic [3:0] starve, starveNext;
  logic owner, fGrant, dGrant, done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    dGrant = state == IDLE && bus.d_req && !(bus.f_req && starve == 4'(STARVE_LIMIT));
    fGrant = state == IDLE && bus.f_req && !dGrant;
    done = state == WAIT && cnt == 3'd1;
    stateNext = (fGrant || dGrant) ? WAIT : done ? IDLE : state;
    starveNext = (fGrant || (state == IDLE && !bus.f_req)) ? 4'd0 :
                 (dGrant && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
  end
  assign bus.f_ack = fGrant;
  assign bus.d_ack = dGrant;
  assign bus.busy = state == WAIT;
  // owner: 1 = load, 0 = fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      starve <= '0;
      owner <= 1'b0;
      bus.mem_addr <= '0;
      bus.rdata <= '0;
      bus.f_valid <= 1'b0;
      bus.d_valid <= 1'b0;
    end else begin
      starve <= starveNext;
      bus.f_valid <= done && !owner;
      bus.d_valid <= done && owner;
      if (fGrant || dGrant) begin
        bus.mem_addr <= dGrant ? bus.d_addr : bus.f_addr;
        owner <= dGrant;
        cnt <= 3'(LAT);
      end else if (state == WAIT) cnt <= cnt - 3'd1;
      if (done) bus.rdata <= bus.mem_data;
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: random fetch/load traffic on LAT=1,2,3 instances, checked against a
// transaction-timing model (accept cycle + LAT) with mid-flight reset.
module tb_mem_read_arbiter;
  localparam int SL = 3;
  logic clk = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int doneCount = 0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:63] memWord(logic [0:60] a);
    return {a, 3'b101} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  function automatic logic [0:60] rndAddr();
    return 61'({$urandom(), $urandom()});
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int L = k + 1;
    logic rst_n;
    mem_read_arbiter_if ifc();
    mem_read_arbiter #(.LAT(L), .STARVE_LIMIT(SL)) dut(.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    assign ifc.mem_data = memWord(ifc.mem_addr);

    initial begin
      int acc, starve;
      bit fly, own, busyE, validNow, fa, da, lastFa, lastDa, fPend, dPend, didReset;
      logic [0:60] txAddr, expAddr;
      logic [0:63] expData;
      acc = -100; starve = 0; fly = 0; own = 0; lastFa = 0; lastDa = 0; didReset = 0;
      txAddr = '0; expAddr = '0; expData = '0;
      rst_n = 1'b0;
      ifc.f_req = 1'b0; ifc.d_req = 1'b0; ifc.f_addr = '0; ifc.d_addr = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        busyE = fly && c <= acc + L;
        validNow = fly && c == acc + L + 1;
        if (!didReset && c >= 100 && busyE && c == acc + (L > 1 ? 2 : 1)) begin
          rst_n = 1'b0;
          ifc.f_req = 1'b0;
          ifc.d_req = 1'b0;
          for (int r = 0; r < 2; r++) begin
            if (r > 0) @(negedge clk);
            #1;
            check($sformatf("L%0d rst f_ack", L), ifc.f_ack, 0);
            check($sformatf("L%0d rst d_ack", L), ifc.d_ack, 0);
            check($sformatf("L%0d rst f_valid", L), ifc.f_valid, 0);
            check($sformatf("L%0d rst d_valid", L), ifc.d_valid, 0);
            check($sformatf("L%0d rst busy", L), ifc.busy, 0);
            check($sformatf("L%0d rst mem_addr", L), 64'(ifc.mem_addr), 0);
            check($sformatf("L%0d rst rdata", L), ifc.rdata, 0);
          end
          @(negedge clk);
          rst_n = 1'b1;
          fly = 0; starve = 0; expAddr = '0; expData = '0; lastFa = 0; lastDa = 0;
          busyE = 0; validNow = 0; didReset = 1;
        end
        fPend = ifc.f_req && !lastFa;
        dPend = ifc.d_req && !lastDa;
        if (c >= 200 && c < 320) begin
          if (!fPend) ifc.f_addr = rndAddr();
          if (!dPend) ifc.d_addr = rndAddr();
          ifc.f_req = 1'b1;
          ifc.d_req = 1'b1;
        end else begin
          if (!fPend) begin
            ifc.f_req = c < 200 ? $urandom_range(3) != 0 : $urandom_range(3) == 0;
            ifc.f_addr = rndAddr();
          end else if ($urandom_range(7) == 0) ifc.f_req = 1'b0;
          if (!dPend) begin
            ifc.d_req = c < 200 ? $urandom_range(3) != 0 : $urandom_range(3) == 0;
            ifc.d_addr = rndAddr();
          end else if ($urandom_range(7) == 0) ifc.d_req = 1'b0;
        end
        #1;
        if (validNow) expData = memWord(txAddr);
        da = !busyE && ifc.d_req && !(ifc.f_req && starve == SL);
        fa = !busyE && ifc.f_req && !da;
        check($sformatf("L%0d c%0d f_ack", L, c), ifc.f_ack, fa);
        check($sformatf("L%0d c%0d d_ack", L, c), ifc.d_ack, da);
        check($sformatf("L%0d c%0d f_valid", L, c), ifc.f_valid, validNow && !own);
        check($sformatf("L%0d c%0d d_valid", L, c), ifc.d_valid, validNow && own);
        check($sformatf("L%0d c%0d busy", L, c), ifc.busy, busyE);
        check($sformatf("L%0d c%0d mem_addr", L, c), 64'(ifc.mem_addr), 64'(expAddr));
        check($sformatf("L%0d c%0d rdata", L, c), ifc.rdata, expData);
        if (fa || (!busyE && !ifc.f_req)) starve = 0;
        else if (da && starve < SL) starve++;
        if (fa || da) begin
          fly = 1;
          acc = c;
          own = da;
          txAddr = da ? ifc.d_addr : ifc.f_addr;
          expAddr = txAddr;
        end else if (validNow) fly = 0;
        lastFa = fa;
        lastDa = da;
      end
      doneCount++;
    end
  end

  initial begin
    wait (doneCount == 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
